seg_display_scanner: RTL and testbench

Parametrised, time-multiplexed seven-segment display driver for N-digit common-anode displays. It adds per-digit decimal points, per-digit blanking and PWM brightness control. Display data updates are tear-free: new values are staged on a load pulse and applied only at a frame boundary. It sits between the bot's status/telemetry logic and the board display pins.

---
 rtl/seg_display_scanner.sv | 162 ++++++++++++++++
 tb/tb_seg_display_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scanner.sv
// Time-multiplexed N-digit common-anode seven-segment driver with PWM brightness and tear-free frame updates.
// Optional leading-zero suppression is enabled by defining SEG_DISPLAY_ZERO_BLANK_EN.
module seg_display_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 10000,
    parameter int DUTY_BITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic                  load,
    input  logic [DUTY_BITS-1:0]  brightness,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n,
    output logic                  frame_done
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PRE_W-1:0]          pre;
    logic [IDX_W-1:0]          idx;
    logic [DUTY_BITS-1:0]      pwm;
    logic                      pre_tc;
    logic                      idx_last;
    logic                      frame_edge;

    logic [DIGITS-1:0][3:0]    stg_data;
    logic [DIGITS-1:0]         stg_dp;
    logic [DIGITS-1:0]         stg_en;
    logic                      pending;
    logic [DIGITS-1:0][3:0]    disp_data;
    logic [DIGITS-1:0]         disp_dp;
    logic [DIGITS-1:0]         disp_en;

    logic [DIGITS-1:0]         supp;
    logic [3:0]                cur_nib;
    logic                      pwm_on;
    logic                      shown;
    logic [6:0]                seg_next;
    logic                      dp_next;
    logic [DIGITS-1:0]         an_next;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    assign pre_tc     = (pre == PRE_W'(REFRESH_DIV - 1));
    assign idx_last   = (idx == IDX_W'(DIGITS - 1));
    assign frame_edge = pre_tc & idx_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            pre        <= '0;
            idx        <= '0;
            pwm        <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            pre        <= pre_tc ? '0 : pre + PRE_W'(1);
            pwm        <= pwm + DUTY_BITS'(1);
            frame_done <= frame_edge;
            if (pre_tc)
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            if (frame_edge)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

    // Staging absorbs loads at any time; the display copy only moves at the frame edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_en    <= '1;
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '1;
        end else begin
            if (load) begin
                stg_data <= data;
                stg_dp   <= dp;
                stg_en   <= digit_en;
            end
            if (frame_edge) begin
                if (load) begin
                    disp_data <= data;
                    disp_dp   <= dp;
                    disp_en   <= digit_en;
                end else if (pending) begin
                    disp_data <= stg_data;
                    disp_dp   <= stg_dp;
                    disp_en   <= stg_en;
                end
            end
        end
    end

`ifdef SEG_DISPLAY_ZERO_BLANK_EN
    // Walk down from the most significant digit; disabled digits are transparent to the walk.
    always_comb begin
        logic leading;
        leading = 1'b1;
        supp    = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (disp_en[i]) begin
                if (leading && (disp_data[i] == 4'h0) && !disp_dp[i])
                    supp[i] = 1'b1;
                else
                    leading = 1'b0;
            end
        end
    end
`else
    assign supp = '0;
`endif

    always_comb begin
        cur_nib      = disp_data[idx];
        pwm_on       = (pwm < brightness);
        shown        = disp_en[idx] & pwm_on & ~supp[idx];
        an_next      = '1;
        an_next[idx] = ~shown;
        seg_next     = shown ? hex_to_seg(cur_nib) : 7'h7F;
        dp_next      = shown ? ~disp_dp[idx] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n <= 7'h7F;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= seg_next;
            dp_n  <= dp_next;
            an_n  <= an_next;
        end
    end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Bench for seg_display_scanner: time-indexed reference model feeding an expected-output queue,
// a table of brightness/dp/enable records, and hand-written frame-boundary sequences.
module tb_seg_display_scanner;

    localparam int D = 4;
    localparam int R = 4;
    localparam int B = 2;
    localparam int FRAME = D * R;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load;
    logic [1:0]  brightness;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    seg_display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .DUTY_BITS(B)) dut (
        .clk(clk), .reset(reset), .data(data), .dp(dp), .digit_en(digit_en),
        .load(load), .brightness(brightness), .seg_n(seg_n), .dp_n(dp_n),
        .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;
    string phase = "init";

    // Reference state: cycle number since reset release plus what the display should hold.
    int          c = 0;
    logic [15:0] m_data = '0, s_data = '0;
    logic [3:0]  m_dp = '0, s_dp = '0;
    logic [3:0]  m_en = '1, s_en = '1;
    logic        m_pend = 1'b0;
    logic [12:0] expq[$];

    logic [6:0]  cap_seg [D];
    int          cap_an, cap_dp;

    typedef struct {
        string       name;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [1:0]  bright;
        int          exp_an;
        int          exp_dp;
    } rec_t;
    rec_t tbl [5];

    function automatic logic [6:0] dec(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s [%s]: got %h, expected %h", name, phase, act, exp);
        end
    endtask

    task automatic tick();
        logic [12:0] e;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        on, sh, sup;
        int          ix;
        if (reset) begin
            e = {7'h7F, 1'b1, 4'hF, 1'b0};
        end else begin
            ix  = (c / R) % D;
            nib = m_data[ix*4 +: 4];
            on  = (c % (1 << B)) < int'(brightness);
            sup = 1'b0;
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
            if (ix != 0 && nib == 4'h0 && !m_dp[ix]) begin
                sup = 1'b1;
                for (int j = ix + 1; j < D; j++)
                    if (m_en[j] && (m_data[j*4 +: 4] != 4'h0 || m_dp[j])) sup = 1'b0;
            end
`endif
            sh = m_en[ix] && on && !sup;
            an = 4'hF;
            an[ix] = ~sh;
            e = {sh ? dec(nib) : 7'h7F, sh ? ~m_dp[ix] : 1'b1, an, (c % FRAME) == FRAME - 1};
        end
        expq.push_back(e);
        if (reset) begin
            c = 0; m_data = '0; m_dp = '0; m_en = '1; m_pend = 1'b0;
        end else begin
            if ((c % FRAME) == FRAME - 1) begin
                if (load) begin
                    m_data = data; m_dp = dp; m_en = digit_en;
                end else if (m_pend) begin
                    m_data = s_data; m_dp = s_dp; m_en = s_en;
                end
                m_pend = 1'b0;
            end else if (load) begin
                s_data = data; s_dp = dp; s_en = digit_en; m_pend = 1'b1;
            end
            c++;
        end
        @(posedge clk);
        #1;
        chk("outputs", 16'({seg_n, dp_n, an_n, frame_done}), 16'(expq.pop_front()));
    endtask

    task automatic align(input int phase_pos);
        int guard = 0;
        while ((c % FRAME) != phase_pos && guard < 4 * FRAME) begin
            tick();
            guard++;
        end
        if (guard >= 4 * FRAME) chk("align_timeout", 16'(guard), 16'(0));
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
        data = d; dp = p; digit_en = en; load = 1'b1;
        tick();
        load = 1'b0; data = 16'hDEAD; dp = 4'h0; digit_en = 4'h0;
    endtask

    task automatic capture_frame();
        align(0);
        for (int k = 0; k < D; k++) cap_seg[k] = 7'h7F;
        cap_an = 0;
        cap_dp = 0;
        for (int n = 0; n < FRAME; n++) begin
            tick();
            if (an_n != 4'hF) begin
                cap_an++;
                if (!dp_n) cap_dp++;
                for (int k = 0; k < D; k++) if (!an_n[k]) cap_seg[k] = seg_n;
            end
        end
    endtask

    task automatic check_frame(input string name, input logic [27:0] exp);
        for (int k = 0; k < D; k++)
            chk($sformatf("%s_digit%0d", name, k), 16'(cap_seg[k]), 16'(exp[k*7 +: 7]));
    endtask

    initial begin
        int fd_cnt;
        tbl[0] = '{"bright0",      16'h8421, 4'b0000, 4'b1111, 2'd0, 0,  0};
        tbl[1] = '{"bright2",      16'h8421, 4'b0000, 4'b1111, 2'd2, 8,  0};
        tbl[2] = '{"dp_digit2",    16'h8421, 4'b0100, 4'b1111, 2'd3, 12, 3};
        tbl[3] = '{"en_1011",      16'h8421, 4'b0000, 4'b1011, 2'd3, 9,  0};
        tbl[4] = '{"bright1_mix",  16'h8421, 4'b1111, 4'b0110, 2'd1, 2,  2};

        reset = 1'b1; data = '0; dp = '0; digit_en = '1; load = 1'b0; brightness = 2'd3;

        phase = "reset";
        repeat (3) tick();
        chk("reset_state", 16'({seg_n, dp_n, an_n, frame_done}), 16'(13'h1FFE));
        reset = 1'b0;

        phase = "scan";
        tick();
        chk("first_an", 16'(an_n), 16'(4'b1110));
        chk("first_seg", 16'(seg_n), 16'(7'b1000000));
        fd_cnt = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            tick();
            if (frame_done) fd_cnt++;
        end
        chk("frame_done_count", 16'(fd_cnt), 16'(2));
        capture_frame();
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
        check_frame("scan_zeros", {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        chk("scan_an_count", 16'(cap_an), 16'(3));
`else
        check_frame("scan_zeros", {4{7'b1000000}});
        chk("scan_an_count", 16'(cap_an), 16'(12));
`endif

        phase = "tear_free";
        repeat (5) tick();
        do_load(16'h12AF, 4'b0000, 4'b1111);
        chk("pending_set", 16'(dut.pending), 16'(1));
        capture_frame();
        check_frame("tear_free", {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110});

        phase = "collision";
        align(FRAME - 1);
        do_load(16'h3456, 4'b0000, 4'b1111);
        chk("pending_after_collision", 16'(dut.pending), 16'(0));
        capture_frame();
        check_frame("collision", {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});
        capture_frame();
        check_frame("collision_hold", {7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});

        for (int r = 0; r < 5; r++) begin
            phase = tbl[r].name;
            brightness = tbl[r].bright;
            do_load(tbl[r].data, tbl[r].dp, tbl[r].en);
            capture_frame();
            chk("an_low_cycles", 16'(cap_an), 16'(tbl[r].exp_an));
            chk("dp_low_cycles", 16'(cap_dp), 16'(tbl[r].exp_dp));
        end

        phase = "zero_blank";
        brightness = 2'd3;
        do_load(16'h0050, 4'b0000, 4'b1111);
        capture_frame();
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
        check_frame("zb_0050", {7'h7F, 7'h7F, 7'b0010010, 7'b1000000});
`else
        check_frame("zb_0050", {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000});
`endif
        do_load(16'h0000, 4'b0000, 4'b1111);
        capture_frame();
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
        check_frame("zb_0000", {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
`else
        check_frame("zb_0000", {4{7'b1000000}});
`endif

        phase = "reset_mid";
        do_load(16'h1234, 4'b0000, 4'b1111);
        capture_frame();
        align(3);
        do_load(16'h9999, 4'b0000, 4'b1111);
        align(9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("pending_after_reset", 16'(dut.pending), 16'(0));
        for (int f = 0; f < 2; f++) begin
            capture_frame();
`ifdef SEG_DISPLAY_ZERO_BLANK_EN
            check_frame("after_reset", {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
`else
            check_frame("after_reset", {4{7'b1000000}});
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
